// File: rtl/cpu_writeback.sv
// Writeback latch, 16x32 register file and two registered read ports.
// Define CPU_WRITEBACK_BYPASS_EN to forward pending writes to reads; otherwise reads flag hazards.
module cpu_writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        register_write_enable_i,
    input  logic [3:0]  register_write_index_i,
    input  logic [31:0] result_i,
    input  logic [3:0]  regA_index_i,
    input  logic [3:0]  regB_index_i,
    output logic [31:0] regA_o,
    output logic [31:0] regB_o,
    output logic        hazard_o,
    output logic        wb_valid_o
);

    // Index 0 = $fp, 1 = $sp, 2..15 = $r0..$r13; no entry is hardwired to zero.
    logic [31:0] reg_file [16];

    // Latch valid/index/data: valid means a write is still to be committed on the next edge.
    logic        wb_valid;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;

    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        hazard_next;

    logic in_hit_a, in_hit_b, wb_hit_a, wb_hit_b;

    always_comb begin
        in_hit_a = register_write_enable_i && (register_write_index_i == regA_index_i);
        in_hit_b = register_write_enable_i && (register_write_index_i == regB_index_i);
        wb_hit_a = wb_valid && (wb_index == regA_index_i);
        wb_hit_b = wb_valid && (wb_index == regB_index_i);
    end

`ifdef CPU_WRITEBACK_BYPASS_EN
    // The incoming write is younger than the latch, so it wins.
    always_comb begin
        rd_a        = reg_file[regA_index_i];
        rd_b        = reg_file[regB_index_i];
        hazard_next = 1'b0;
        if (in_hit_a)      rd_a = result_i;
        else if (wb_hit_a) rd_a = wb_data;
        if (in_hit_b)      rd_b = result_i;
        else if (wb_hit_b) rd_b = wb_data;
    end
`else
    always_comb begin
        rd_a        = reg_file[regA_index_i];
        rd_b        = reg_file[regB_index_i];
        hazard_next = in_hit_a || in_hit_b || wb_hit_a || wb_hit_b;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                reg_file[i] <= 32'h0;
            end
            wb_valid <= 1'b0;
            wb_index <= 4'h0;
            wb_data  <= 32'h0;
            regA_o   <= 32'h0;
            regB_o   <= 32'h0;
            hazard_o <= 1'b0;
        end else begin
            // Commit happens regardless of stall; a same-edge capture refills the latch.
            if (wb_valid) begin
                reg_file[wb_index] <= wb_data;
            end
            if (!stall_i) begin
                wb_valid <= register_write_enable_i;
                wb_index <= register_write_index_i;
                wb_data  <= result_i;
                regA_o   <= rd_a;
                regB_o   <= rd_b;
                hazard_o <= hazard_next;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign wb_valid_o = wb_valid;

endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 Port clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 Port rst_i  input  1  reset; asynchronous, active-high.
REQ-003 Port stall_i  input  1  pipeline stall from hazard control.
REQ-004 Port register_write_enable_i  input  1  execute-stage write request.
REQ-005 Port register_write_index_i  input  4  destination register index, 0..15.
REQ-006 Port result_i  input  32  execute-stage result data.
REQ-007 Port regA_index_i  input  4  read port A register index.
REQ-008 Port regB_index_i  input  4  read port B register index.
REQ-009 Port regA_o  output  32  registered read data, port A.
REQ-010 Port regB_o  output  32  registered read data, port B.
REQ-011 Port hazard_o  output  1  registered flag: a read hit an uncommitted write.
REQ-012 Port wb_valid_o  output  1  writeback latch holds an uncommitted write.

Function
REQ-013 The block SHALL hold a 16 x 32-bit register file (index 0 = $fp, 1 = $sp, 2..15 = $r0..$r13), with no hardwired-zero entry.
REQ-014 Stage WB-capture: on an edge with stall_i=0, the latch SHALL load valid=register_write_enable_i, index=register_write_index_i, data=result_i.
REQ-015 Stage WB-commit: on every edge where latch valid=1, the file entry at latch index SHALL be written with latch data, regardless of stall_i.
REQ-016 On an edge with stall_i=1, the latch SHALL become valid=0 after committing; a write presented while stalled SHALL be discarded.
REQ-017 Write latency: result_i visible in the file 2 edges after presentation; wb_valid_o SHALL equal latch valid.
REQ-018 Capture and commit on the same edge SHALL both take effect, including the same index; the younger value is then in the latch.
REQ-019 Read latency: regA_o/regB_o SHALL update 1 edge after the index is presented, when stall_i=0.
REQ-020 While stall_i=1, regA_o, regB_o and hazard_o SHALL hold their values.
REQ-021 Read-source priority (bypass build): incoming write (enable_i=1, index match) first, then valid latch index match, then file contents.
REQ-022 Both read ports SHALL be independent; identical indices SHALL return identical data.
REQ-023 An index match with register_write_enable_i=0 or latch valid=0 SHALL NOT forward.

Reset
REQ-024 While rst_i=1, all 16 file entries, regA_o, regB_o, latch data and index SHALL be 0x00000000/0, and hazard_o and wb_valid_o SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard any pending latch write with no file update.
REQ-026 On the first edge after rst_i falls, normal capture and read SHALL resume.

Configuration
REQ-027 Macro CPU_WRITEBACK_BYPASS_EN SHALL select the forwarding build.
REQ-028 With CPU_WRITEBACK_BYPASS_EN defined: REQ-021 forwarding applies and hazard_o SHALL be constant 0.
REQ-029 Without the macro: reads SHALL return file contents only. hazard_o SHALL be registered 1 when either read index matches an enabled incoming write or a valid latch entry, and 0 otherwise.

Verification
REQ-030 Reset, then read all 16 indices on both ports -> every read is 0x00000000, hazard_o=0, wb_valid_o=0.
REQ-031 Write idx 3 = 0xDEADBEEF, then idle 2 cycles, then read A=3, B=3 -> both ports return 0xDEADBEEF.
REQ-032 Bypass build: write idx 5 = 0x12345678 and read A=5 in the same cycle -> regA_o=0x12345678 next edge. Next cycle write idx 5 = 0x0000000A and read B=5 -> regB_o=0x0000000A, because the incoming write beats the latch.
REQ-033 No-bypass build: write idx 7 = 0x55AA55AA with the file value 0, and read A=7 in the same cycle -> regA_o=0, hazard_o=1. Read again 2 cycles later -> regA_o=0x55AA55AA, hazard_o=0.
REQ-034 Write idx 2 = 0x00000001 with stall_i=1 on that edge -> wb_valid_o=0 and the file is unchanged. A pending latch write presented the cycle before the stall still commits.
REQ-035 Assert rst_i asynchronously (between edges) while the latch holds idx 9 = 0xFFFFFFFF -> outputs go to 0 immediately, and idx 9 reads 0 after release.
